// File: rtl/grng_hat_sched.sv
// grng_hat_sched
// Request scheduler and sequencer for the multihat Gaussian sample pipeline.
// Shares one fixed-latency, non-stallable hat multiplier pipeline between NREQ
// consumers. Uniform words from the URNG are issued one per cycle at most. Each
// issued word carries its requester ID through a tag shift register that matches
// the pipeline latency. The pipeline result is captured into a result FIFO
// together with that ID. A credit rule (FIFO occupancy + tags in flight <
// FDEPTH) means the FIFO can never overflow, so the pipeline never has to stall.
//
// Ports
//   i_clk          single clock, all logic on posedge
//   i_reset        synchronous active-low reset (0 = reset)
//   i_req          level request per consumer, held until its ack bit is seen
//   o_ack          one-hot, one-cycle grant pulse (the sample has been issued)
//   i_urng_valid   i_urng_data is valid
//   i_urng_data    32-bit uniform random word
//   o_urng_ready   word consumed this cycle (same as issue)
//   o_hat_in       hat pipeline input
//   i_hat_out      hat pipeline output, LAT edges after o_hat_in
//   o_out_valid    result FIFO not empty
//   i_out_ready    consumer accepts the head sample
//   o_out_data     Gaussian sample at the FIFO head
//   o_out_id       requester ID of the head sample
//   o_busy         any tag in flight or FIFO not empty
module grng_hat_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LAT    = 3,
  parameter int unsigned FDEPTH = 4,
  parameter int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_ack,
  input  logic            i_urng_valid,
  input  logic [31:0]     i_urng_data,
  output logic            o_urng_ready,
  output logic [31:0]     o_hat_in,
  input  logic [15:0]     i_hat_out,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [15:0]     o_out_data,
  output logic [IDW-1:0]  o_out_id,
  output logic            o_busy
);

  localparam int unsigned PW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CW  = $clog2(FDEPTH + 1);
  localparam int unsigned IFW = $clog2(LAT + 1);

  // Tag pipeline: one {valid, id} entry per hat pipeline stage.
  logic [LAT-1:0] r_tag_valid;
  logic [IDW-1:0] r_tag_id [LAT];

  // Issue-side state.
  logic [31:0]    r_last_word;
  logic [IDW-1:0] r_last_grant;

  // Result FIFO.
  logic [15:0]    r_fifo_data [FDEPTH];
  logic [IDW-1:0] r_fifo_id   [FDEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  logic [IFW-1:0] w_inflight;
  logic           w_credit_ok;
  logic           w_issue;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_cand;
  logic           w_found;
  logic           w_push;
  logic           w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (32'(ptr) == FDEPTH - 1) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  // Exact count of valid tags; a popcount keeps it correct across resets.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + IFW'(r_tag_valid[i]);
    end
  end

  // Registered values only: a pop this cycle does not free a credit until next cycle,
  // which keeps o_ack/o_urng_ready independent of i_out_ready.
  assign w_credit_ok = (32'(r_count) + 32'(w_inflight)) < FDEPTH;

  // Round-robin: search starts one past the last grant and wraps modulo NREQ.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((32'(r_last_grant) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_issue = i_urng_valid & w_found & w_credit_ok;

  always_comb begin
    o_ack = '0;
    if (w_issue) begin
      o_ack[w_winner] = 1'b1;
    end
  end

  assign o_urng_ready = w_issue;
  // Hold the previous word when idle so the pipeline's mixing bits stay stable.
  assign o_hat_in     = w_issue ? i_urng_data : r_last_word;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last_word  <= '0;
      r_last_grant <= IDW'(NREQ - 1);
    end else if (w_issue) begin
      r_last_word  <= i_urng_data;
      r_last_grant <= w_winner;
    end
  end

  // Clearing the valid bits is what discards samples already in the hat pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_tag_valid <= '0;
    end else begin
      r_tag_valid[0] <= w_issue;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
      end
    end
  end

  // IDs are only meaningful alongside a valid bit, so they need no reset.
  always_ff @(posedge i_clk) begin
    r_tag_id[0] <= w_winner;
    for (int unsigned i = 1; i < LAT; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_push = r_tag_valid[LAT-1];
  assign w_pop  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_tail] <= i_hat_out;
      r_fifo_id[r_tail]   <= r_tag_id[LAT-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_out_valid = (r_count != '0);
  assign o_out_data  = r_fifo_data[r_head];
  assign o_out_id    = r_fifo_id[r_head];
  assign o_busy      = (w_inflight != '0) | o_out_valid;

endmodule

// File: tb/tb_grng_hat_sched.sv
// Bench for grng_hat_sched: a stand-in 3-stage hat pipeline, a transaction-level
// reference model (queues of in-flight and buffered samples), table-driven
// round-robin vectors, hand sequences for the corner cases and a random phase.
module tb_grng_hat_sched;

  localparam int NREQ   = 4;
  localparam int LAT    = 3;
  localparam int FDEPTH = 4;
  localparam int IDW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            uv;
  logic [31:0]     ud;
  logic            ordy;
  logic [15:0]     hat_out;
  logic [NREQ-1:0] ack;
  logic            urdy;
  logic [31:0]     hat_in;
  logic            ov;
  logic [15:0]     od;
  logic [IDW-1:0]  oid;
  logic            busy;

  always #5 clk = ~clk;

  grng_hat_sched #(
    .NREQ  (NREQ),
    .LAT   (LAT),
    .FDEPTH(FDEPTH),
    .IDW   (IDW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req       (req),
    .o_ack       (ack),
    .i_urng_valid(uv),
    .i_urng_data (ud),
    .o_urng_ready(urdy),
    .o_hat_in    (hat_in),
    .i_hat_out   (hat_out),
    .o_out_valid (ov),
    .i_out_ready (ordy),
    .o_out_data  (od),
    .o_out_id    (oid),
    .o_busy      (busy)
  );

  function automatic logic [15:0] hat_f(input logic [31:0] w);
    return 16'(w[31:16] * 3) ^ {w[7:0], w[15:8]};
  endfunction

  // Stand-in hat pipeline: LAT stages, no reset.
  logic [15:0] hp [LAT];
  always @(posedge clk) begin
    hp[0] <= hat_f(hat_in);
    for (int i = 1; i < LAT; i++) hp[i] <= hp[i-1];
  end
  assign hat_out = hp[LAT-1];

  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic [15:0]    d;
  } pend_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    d;
  } res_t;

  pend_t       m_pend[$];
  res_t        m_fifo[$];
  int          m_lg;
  logic [31:0] m_lw;
  int          cyc;
  logic        e_issue;
  int          e_win;
  logic [3:0]  e_ack;

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Predict this cycle's outputs from the model and compare at the negedge.
  task automatic step_begin();
    @(negedge clk);
    e_issue = 1'b0;
    e_win   = 0;
    if (uv && req != 0 && (m_fifo.size() + m_pend.size() < FDEPTH)) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_lg + k) % NREQ;
        if (!e_issue && req[idx[IDW-1:0]]) begin
          e_issue = 1'b1;
          e_win   = idx;
        end
      end
    end
    e_ack = e_issue ? 4'(32'd1 << e_win) : 4'd0;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("urng_ready", 32'(urdy), 32'(e_issue));
    chk("hat_in", hat_in, e_issue ? ud : m_lw);
    chk("out_valid", 32'(ov), 32'(m_fifo.size() != 0));
    chk("busy", 32'(busy), 32'((m_fifo.size() != 0) || (m_pend.size() != 0)));
    if (m_fifo.size() != 0) begin
      chk("out_id", 32'(oid), 32'(m_fifo[0].id));
      chk("out_data", 32'(od), 32'(m_fifo[0].d));
    end
  endtask

  // Advance the model across the posedge, then release inputs for the next cycle.
  task automatic step_end();
    pend_t p;
    res_t  r;
    @(posedge clk);
    if (!rst_n) begin
      m_pend.delete();
      m_fifo.delete();
      m_lg = NREQ - 1;
      m_lw = 32'h0;
    end else begin
      if (ordy && m_fifo.size() != 0) void'(m_fifo.pop_front());
      if (m_pend.size() != 0 && m_pend[0].due == cyc) begin
        p    = m_pend.pop_front();
        r.id = p.id;
        r.d  = p.d;
        m_fifo.push_back(r);
      end
      if (e_issue) begin
        p.due = cyc + LAT;
        p.id  = IDW'(e_win);
        p.d   = hat_f(ud);
        m_pend.push_back(p);
        m_lg = e_win;
        m_lw = ud;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    step_begin();
    step_end();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    uv    = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    req = '0;
    uv  = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Under the credit rule a push must never land on a full FIFO.
  always @(negedge clk) begin
    if (rst_n && dut.w_push && !dut.w_pop && 32'(dut.r_count) == FDEPTH) begin
      miss++;
      $display("FAIL push_when_full cycle %0d: count %0d, required < %0d",
               cyc, dut.r_count, FDEPTH);
    end
  end

  typedef struct {
    logic [3:0]     req;
    logic [3:0]     ack;
    logic           ov;
    logic [IDW-1:0] id;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Round-robin with req=1111, out_ready=1: credits cause one bubble per lap.
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 4'h2, 1'b0, 2'd0};
    tbl[2]  = '{4'hF, 4'h4, 1'b0, 2'd0};
    tbl[3]  = '{4'hF, 4'h8, 1'b0, 2'd0};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 2'd0};
    tbl[5]  = '{4'hF, 4'h1, 1'b1, 2'd1};
    tbl[6]  = '{4'hF, 4'h2, 1'b1, 2'd2};
    tbl[7]  = '{4'hF, 4'h4, 1'b1, 2'd3};
    tbl[8]  = '{4'hF, 4'h8, 1'b0, 2'd0};
    tbl[9]  = '{4'h0, 4'h0, 1'b1, 2'd0};
    tbl[10] = '{4'h0, 4'h0, 1'b1, 2'd1};
    tbl[11] = '{4'h0, 4'h0, 1'b1, 2'd2};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 2'd3};
    tbl[13] = '{4'h0, 4'h0, 1'b0, 2'd0};

    rst_n = 1'b0;
    req   = '0;
    uv    = 1'b0;
    ud    = 32'h0;
    ordy  = 1'b0;
    m_lg  = NREQ - 1;
    m_lw  = 32'h0;
    cyc   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values.
    step_begin();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_ready", 32'(urdy), 32'h0);
    chk("rst_out_valid", 32'(ov), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hat_in", hat_in, 32'h0);
    step_end();

    // Single request.
    req  = 4'b0001;
    uv   = 1'b1;
    ud   = 32'hA468DAF5;
    ordy = 1'b1;
    step_begin();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_ready", 32'(urdy), 32'h1);
    step_end();
    req = '0;
    uv  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step_begin();
      if (c < 4) chk("single_no_out", 32'(ov), 32'h0);
      if (c == 4) begin
        chk("single_out_valid", 32'(ov), 32'h1);
        chk("single_out_id", 32'(oid), 32'h0);
        chk("single_out_data", 32'(od), 32'(hat_f(32'hA468DAF5)));
      end
      if (c == 5) chk("single_busy_after_pop", 32'(busy), 32'h0);
      step_end();
    end

    // Round-robin table.
    do_reset();
    uv   = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      ud  = $urandom;
      step_begin();
      chk($sformatf("rr_ack[%0d]", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("rr_out_valid[%0d]", i), 32'(ov), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("rr_out_id[%0d]", i), 32'(oid), 32'(tbl[i].id));
      step_end();
    end

    // Backpressure.
    do_reset();
    req  = 4'b0100;
    uv   = 1'b1;
    ordy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ud = $urandom;
      step_begin();
      if (c < 4) chk("bp_ack", 32'(ack), 32'h4);
      else chk("bp_stalled", 32'(urdy), 32'h0);
      step_end();
    end
    ordy = 1'b1;
    step_begin();
    chk("bp_pop_no_credit", 32'(urdy), 32'h0);
    step_end();
    ordy = 1'b0;
    step_begin();
    chk("bp_freed_issue", 32'(ack), 32'h4);
    step_end();
    step_begin();
    chk("bp_stalled_again", 32'(urdy), 32'h0);
    step_end();
    idle(10);

    // Sparse requests, last_grant = 1 first.
    do_reset();
    req = 4'b0010;
    uv  = 1'b1;
    ud  = $urandom;
    step();
    idle(6);
    uv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req = (c == 3) ? 4'b0010 : 4'b1010;
      ud  = $urandom;
      step_begin();
      chk($sformatf("sparse_ack[%0d]", c), 32'(ack), (c == 0 || c == 2) ? 32'h8 : 32'h2);
      step_end();
    end
    idle(8);

    // URNG starvation.
    req = 4'b1111;
    uv  = 1'b1;
    ud  = 32'h3E83CBE5;
    step();
    uv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ud = $urandom;
      step_begin();
      chk("starve_ack", 32'(ack), 32'h0);
      chk("starve_ready", 32'(urdy), 32'h0);
      chk("starve_hat_in", hat_in, 32'h3E83CBE5);
      step_end();
    end
    idle(8);

    // Reset with samples both in flight and buffered.
    do_reset();
    req  = 4'b0001;
    uv   = 1'b1;
    ordy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ud = $urandom;
      step();
    end
    req = '0;
    uv  = 1'b0;
    step();
    step_begin();
    chk("mid_fifo_nonempty", 32'(ov), 32'h1);
    step_end();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step_begin();
      chk("mid_no_stale_valid", 32'(ov), 32'h0);
      chk("mid_not_busy", 32'(busy), 32'h0);
      step_end();
    end
    req  = 4'b1111;
    uv   = 1'b1;
    ordy = 1'b1;
    ud   = $urandom;
    step_begin();
    chk("mid_first_grant", 32'(ack), 32'h1);
    step_end();
    idle(8);

    // Random traffic against the model; requests held until acked.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      uv    = ($urandom_range(0, 4) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      ud    = $urandom;
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      req = req & ~e_ack;
    end
    rst_n = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
